// File: rtl/scpad_tile_walker.sv
// scpad_tile_walker: walks a 2-D tile held in a banked scratchpad and emits one
// registered descriptor beat per cycle (per-bank slot, lane and enable masks).
// Build option SCPAD_WALKER_SKEW_EN: skewed layout, where each tile row is
// rotated across the banks by its row index so that a column walk touches every
// row in a single conflict-free beat. When SCPAD_WALKER_SKEW_EN is not defined,
// a column walk emits one element per beat.
module scpad_tile_walker #(
   parameter  int NUM_COLS      = 32,
   parameter  int ELEM_BITS     = 16,
   parameter  int NUM_ROWS      = 32768,
   parameter  int NUM_SCPADS    = 2,
   parameter  int MAX_TILE_SIZE = 32,
   localparam int DIMW = $clog2(MAX_TILE_SIZE),
   localparam int AW   = $clog2(NUM_ROWS*NUM_COLS*ELEM_BITS/8),
   localparam int SIDW = $clog2(NUM_SCPADS),
   localparam int SW   = $clog2(NUM_ROWS),
   localparam int CW   = $clog2(NUM_COLS)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [AW-1:0]          req_addr,
   input  logic [DIMW-1:0]        req_num_rows,
   input  logic [DIMW-1:0]        req_num_cols,
   input  logic                   req_row_or_col,
   input  logic [SIDW-1:0]        req_scpad_id,
   output logic                   beat_valid,
   input  logic                   beat_ready,
   output logic                   beat_write,
   output logic [SIDW-1:0]        beat_scpad_id,
   output logic [NUM_COLS*SW-1:0] beat_slot_mask,
   output logic [NUM_COLS*CW-1:0] beat_shift_mask,
   output logic [NUM_COLS-1:0]    beat_valid_mask,
   output logic                   beat_last,
   output logic                   done
);

`ifdef SCPAD_WALKER_SKEW_EN
   localparam bit LP_SKEW = 1'b1;
`else
   localparam bit LP_SKEW = 1'b0;
`endif

   localparam int EB = $clog2(ELEM_BITS/8);
   localparam int RB = $clog2(NUM_COLS*ELEM_BITS/8);

   typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_t;

   state_t                r_state;
   logic                  r_ready;
   logic                  r_bvalid;
   logic                  r_done;
   logic                  r_last;
   logic                  r_write;
   logic [SIDW-1:0]       r_sid;
   logic [SW-1:0]         r_br;
   logic [CW-1:0]         r_bc;
   logic [DIMW-1:0]       r_nr;
   logic [DIMW-1:0]       r_nc;
   logic                  r_rc;
   logic [DIMW-1:0]       r_bi;
   logic [DIMW-1:0]       r_ei;
   logic [NUM_COLS*SW-1:0] r_slot;
   logic [NUM_COLS*CW-1:0] r_shift;
   logic [NUM_COLS-1:0]   r_vmask;

   logic [SW-1:0]         w_br;
   logic [CW-1:0]         w_bc;
   logic [DIMW-1:0]       w_nr;
   logic [DIMW-1:0]       w_nc;
   logic                  w_rc;
   logic [DIMW-1:0]       w_bi;
   logic [DIMW-1:0]       w_ei;
   logic                  w_last;
   logic [CW-1:0]         w_k;
   logic [NUM_COLS*SW-1:0] w_slot;
   logic [NUM_COLS*CW-1:0] w_shift;
   logic [NUM_COLS-1:0]   w_vmask;

   // Select the tile fields and the index of the beat to be loaded next:
   // beat 0 of the incoming request in IDLE, the following beat in ISSUE.
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_br = SW'(req_addr >> RB);
         w_bc = CW'(req_addr >> EB);
         w_nr = req_num_rows;
         w_nc = req_num_cols;
         w_rc = req_row_or_col;
         w_bi = '0;
         w_ei = '0;
      end else begin
         w_br = r_br;
         w_bc = r_bc;
         w_nr = r_nr;
         w_nc = r_nc;
         w_rc = r_rc;
         w_bi = r_bi;
         w_ei = r_ei;
         if (r_rc && !LP_SKEW) begin
            if (r_ei == r_nr) begin
               w_ei = '0;
               w_bi = r_bi + DIMW'(1);
            end else begin
               w_ei = r_ei + DIMW'(1);
            end
         end else begin
            w_bi = r_bi + DIMW'(1);
         end
      end
   end

   // Build the per-bank masks of the selected beat. Each bank inverts the layout
   // mapping: w_k is the tile column (row walk) or row (skewed column walk)
   // that would sit in this bank, and the bank is enabled if that index is
   // inside the tile.
   always_comb begin
      w_slot  = '0;
      w_shift = '0;
      w_vmask = '0;
      w_k     = '0;
      for (int unsigned b = 0; b < NUM_COLS; b++) begin
         w_k = CW'(b) - w_bc - (LP_SKEW ? CW'(w_bi) : CW'(0));
         if (!w_rc) begin
            if (32'(w_k) <= 32'(w_nc)) begin
               w_vmask[b]          = 1'b1;
               w_slot[b*SW +: SW]  = w_br + SW'(w_bi);
               w_shift[b*CW +: CW] = w_k;
            end
         end else if (LP_SKEW) begin
            if (32'(w_k) <= 32'(w_nr)) begin
               w_vmask[b]          = 1'b1;
               w_slot[b*SW +: SW]  = w_br + SW'(w_k);
               w_shift[b*CW +: CW] = w_k;
            end
         end else begin
            if (w_k == CW'(w_bi)) begin
               w_vmask[b]          = 1'b1;
               w_slot[b*SW +: SW]  = w_br + SW'(w_ei);
               w_shift[b*CW +: CW] = CW'(w_ei);
            end
         end
      end
      if (!w_rc) begin
         w_last = (w_bi == w_nr);
      end else if (LP_SKEW) begin
         w_last = (w_bi == w_nc);
      end else begin
         w_last = (w_bi == w_nc) && (w_ei == w_nr);
      end
   end

   // Walker FSM: latch the request, present registered beats, hold them under
   // backpressure, and return to IDLE with a done pulse after the last beat.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_ready  <= 1'b1;
         r_bvalid <= 1'b0;
         r_done   <= 1'b0;
         r_last   <= 1'b0;
         r_write  <= 1'b0;
         r_sid    <= '0;
         r_br     <= '0;
         r_bc     <= '0;
         r_nr     <= '0;
         r_nc     <= '0;
         r_rc     <= 1'b0;
         r_bi     <= '0;
         r_ei     <= '0;
         r_slot   <= '0;
         r_shift  <= '0;
         r_vmask  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_state  <= ST_ISSUE;
                  r_ready  <= 1'b0;
                  r_write  <= req_write;
                  r_sid    <= req_scpad_id;
                  r_br     <= w_br;
                  r_bc     <= w_bc;
                  r_nr     <= w_nr;
                  r_nc     <= w_nc;
                  r_rc     <= w_rc;
                  r_bi     <= w_bi;
                  r_ei     <= w_ei;
                  r_bvalid <= 1'b1;
                  r_last   <= w_last;
                  r_slot   <= w_slot;
                  r_shift  <= w_shift;
                  r_vmask  <= w_vmask;
               end
            end
            ST_ISSUE: begin
               if (beat_ready) begin
                  if (r_last) begin
                     r_state  <= ST_IDLE;
                     r_ready  <= 1'b1;
                     r_done   <= 1'b1;
                     r_bvalid <= 1'b0;
                     r_last   <= 1'b0;
                     r_bi     <= '0;
                     r_ei     <= '0;
                     r_slot   <= '0;
                     r_shift  <= '0;
                     r_vmask  <= '0;
                  end else begin
                     r_bi    <= w_bi;
                     r_ei    <= w_ei;
                     r_last  <= w_last;
                     r_slot  <= w_slot;
                     r_shift <= w_shift;
                     r_vmask <= w_vmask;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready       = r_ready;
   assign beat_valid      = r_bvalid;
   assign beat_write      = r_write;
   assign beat_scpad_id   = r_sid;
   assign beat_slot_mask  = r_slot;
   assign beat_shift_mask = r_shift;
   assign beat_valid_mask = r_vmask;
   assign beat_last       = r_last;
   assign done            = r_done;

endmodule

// File: tb/tb_scpad_tile_walker.sv
// Scoreboard bench for scpad_tile_walker: a behavioural model places every
// tile element into its beat/bank and queues the expected beats; a monitor
// compares every accepted beat, hold-stability under stalls and done pulses.
module tb_scpad_tile_walker;

`ifdef SCPAD_WALKER_SKEW_EN
   localparam bit SKEW = 1'b1;
`else
   localparam bit SKEW = 1'b0;
`endif

   localparam int NC   = 32;
   localparam int NR   = 32768;
   localparam int AW   = 21;
   localparam int DIMW = 5;
   localparam int SIDW = 1;
   localparam int SW   = 15;
   localparam int CW   = 5;
   localparam int ROWB = 64;
   localparam int ELB  = 2;

   logic                CLK = 1'b0;
   logic                RST;
   logic                req_valid;
   logic                req_ready;
   logic                req_write;
   logic [AW-1:0]       req_addr;
   logic [DIMW-1:0]     req_num_rows;
   logic [DIMW-1:0]     req_num_cols;
   logic                req_row_or_col;
   logic [SIDW-1:0]     req_scpad_id;
   logic                beat_valid;
   logic                beat_ready;
   logic                beat_write;
   logic [SIDW-1:0]     beat_scpad_id;
   logic [NC*SW-1:0]    beat_slot_mask;
   logic [NC*CW-1:0]    beat_shift_mask;
   logic [NC-1:0]       beat_valid_mask;
   logic                beat_last;
   logic                done;

   scpad_tile_walker #(
      .NUM_COLS      (NC),
      .ELEM_BITS     (16),
      .NUM_ROWS      (NR),
      .NUM_SCPADS    (2),
      .MAX_TILE_SIZE (32)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_num_rows    (req_num_rows),
      .req_num_cols    (req_num_cols),
      .req_row_or_col  (req_row_or_col),
      .req_scpad_id    (req_scpad_id),
      .beat_valid      (beat_valid),
      .beat_ready      (beat_ready),
      .beat_write      (beat_write),
      .beat_scpad_id   (beat_scpad_id),
      .beat_slot_mask  (beat_slot_mask),
      .beat_shift_mask (beat_shift_mask),
      .beat_valid_mask (beat_valid_mask),
      .beat_last       (beat_last),
      .done            (done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic             wr;
      logic [SIDW-1:0]  sid;
      logic [NC*SW-1:0] slot;
      logic [NC*CW-1:0] shift;
      logic [NC-1:0]    vmask;
      logic             last;
   } beat_t;

   beat_t sb[$];

   int n_cmp  = 0;
   int n_err  = 0;
   int n_acc  = 0;
   int n_done = 0;
   int acc0, done0, exp_nb;
   int ready_mode = 0;
   int pidx = 0;
   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: assign every element (r,c) to its beat and bank.
   task automatic model_push(input logic wr, input logic [AW-1:0] addr, input int nr,
                             input int nc, input logic rc, input logic [SIDW-1:0] sid,
                             output int nb);
      int br, bc;
      br = int'(addr) / ROWB;
      bc = (int'(addr) / ELB) % NC;
      if (!rc) nb = nr + 1;
      else if (SKEW) nb = nc + 1;
      else nb = (nr + 1) * (nc + 1);
      for (int k = 0; k < nb; k++) begin
         beat_t e;
         e.wr = wr; e.sid = sid; e.slot = '0; e.shift = '0; e.vmask = '0;
         e.last = (k == nb - 1);
         for (int r = 0; r <= nr; r++) begin
            for (int c = 0; c <= nc; c++) begin
               int owner, bank;
               if (!rc) owner = r;
               else if (SKEW) owner = c;
               else owner = c * (nr + 1) + r;
               if (owner == k) begin
                  bank = (bc + c + (SKEW ? r : 0)) % NC;
                  e.vmask[bank] = 1'b1;
                  e.slot[bank*SW +: SW]  = SW'((br + r) % NR);
                  e.shift[bank*CW +: CW] = CW'(rc ? r : c);
               end
            end
         end
         sb.push_back(e);
      end
   endtask

   // beat_ready driver: always ready, random, or the fixed 1,0,0,1 pattern
   initial begin
      beat_ready = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         case (ready_mode)
            0: beat_ready = 1'b1;
            1: beat_ready = ($urandom % 4) != 0;
            default: begin
               beat_ready = pat[pidx];
               pidx = (pidx + 1) % 4;
            end
         endcase
      end
   end

   // Monitor: pop/compare accepted beats, check stall stability and done
   bit pend = 0, stall = 0, exp_done;
   logic [675:0] snap, cur;
   always @(negedge CLK) begin
      cur = {beat_valid, beat_write, beat_scpad_id, beat_last, beat_valid_mask,
             beat_slot_mask, beat_shift_mask};
      if (RST) begin
         pend = 0;
         stall = 0;
      end else begin
         exp_done = pend;
         pend = 0;
         if (done || exp_done) begin
            check("done_pulse", done, exp_done);
            if (done) n_done++;
            if (exp_done) check("ready_on_done", req_ready, 1);
         end
         if (stall) check("hold_stable", cur == snap, 1);
         stall = 0;
         if (beat_valid) begin
            if (beat_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_beat", beat_valid, 0);
               end else begin
                  beat_t e;
                  e = sb.pop_front();
                  check("vmask", beat_valid_mask, e.vmask);
                  check("slot", beat_slot_mask, e.slot);
                  check("shift", beat_shift_mask, e.shift);
                  check("write", beat_write, e.wr);
                  check("scpad_id", beat_scpad_id, e.sid);
                  check("last", beat_last, e.last);
                  n_acc++;
                  pend = e.last;
               end
            end else begin
               stall = 1;
               snap = cur;
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_req_ready"}, req_ready, 1);
      check({tag, "_beat_valid"}, beat_valid, 0);
      check({tag, "_beat_last"}, beat_last, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_vmask"}, beat_valid_mask, 0);
      check({tag, "_slot"}, beat_slot_mask, 0);
      check({tag, "_shift"}, beat_shift_mask, 0);
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] addr, input int nr, input int nc,
                        input logic rc, input logic [SIDW-1:0] sid);
      model_push(wr, addr, nr, nc, rc, sid, exp_nb);
      acc0  = n_acc;
      done0 = n_done;
      check("req_ready_idle", req_ready, 1);
      req_valid      = 1'b1;
      req_write      = wr;
      req_addr       = addr;
      req_num_rows   = DIMW'(nr);
      req_num_cols   = DIMW'(nc);
      req_row_or_col = rc;
      req_scpad_id   = sid;
      pidx = 0;
      @(posedge CLK);
      #1 req_valid = 1'b0;
      @(negedge CLK);
      check("first_beat_valid", beat_valid, 1);
   endtask

   task automatic wait_done();
      bit seen;
      int lim;
      seen = 0;
      lim  = 8 * exp_nb + 40;
      for (int i = 0; i < lim && !seen; i++) begin
         @(negedge CLK);
         #1;
         if (done) seen = 1;
      end
      check("done_seen", seen, 1);
      check("beats_accepted", n_acc - acc0, exp_nb);
      check("done_count", n_done - done0, 1);
   endtask

   initial begin
      RST = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_num_rows = '0;
      req_num_cols = '0; req_row_or_col = 1'b0; req_scpad_id = '0;
      repeat (3) @(negedge CLK);
      check_reset_state("reset");
      #2 RST = 1'b0;
      @(negedge CLK);
      #1;

      // small row read tile at address 0
      issue(1'b0, '0, 3, 3, 1'b0, 1'b0);
      wait_done();
      // maximum tile, column write
      issue(1'b1, '0, 31, 31, 1'b1, 1'b1);
      wait_done();
      // backpressure 1,0,0,1 on a 4-beat tile
      ready_mode = 2;
      issue(1'b0, AW'(ROWB * 7 + ELB * 5), 3, 3, 1'b0, 1'b0);
      wait_done();
      ready_mode = 0;
      // slot and bank wrap
      issue(1'b0, AW'((NR - 1) * ROWB + 30 * ELB), 1, 3, 1'b0, 1'b1);
      wait_done();
      // 2x2 column walk
      issue(1'b0, '0, 1, 1, 1'b1, 1'b0);
      wait_done();

      // reset during beat 2 of an 8-beat tile
      issue(1'b1, AW'(ROWB * 3), 7, 3, 1'b0, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      check("rst_async_valid", beat_valid, 0);
      check("rst_async_done", done, 0);
      check("rst_async_ready", req_ready, 1);
      sb.delete();
      @(negedge CLK);
      check_reset_state("midtile");
      check("no_done_after_abort", n_done - done0, 0);
      #2 RST = 1'b0;
      issue(1'b0, AW'(ROWB * 100 + ELB * 9), 2, 4, 1'b0, 1'b1);
      wait_done();

      // randomized tiles with random backpressure
      ready_mode = 1;
      for (int t = 0; t < 24; t++) begin
         issue(1'($urandom), AW'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
               1'($urandom), SIDW'($urandom));
         wait_done();
      end
      ready_mode = 0;

      repeat (5) @(negedge CLK);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
